// File: rtl/dilithium_core_arbiter_if.sv
// Bundles the client and core stream/control signals around the shared Dilithium core.
// The slave modport is the arbiter's view. The master modport is the view of the
// clients plus the core.
interface dilithium_core_arbiter_if #(
    parameter int unsigned W     = 64,
    parameter int unsigned N_CLI = 2
);
    // Client control
    logic [N_CLI-1:0]        req;
    logic [1:0]              mode0;
    logic [1:0]              mode1;
    logic [N_CLI-1:0]        gnt;
    logic [N_CLI-1:0]        cli_done;

    // Client streams
    logic [N_CLI-1:0]        cli_valid_i;
    logic [N_CLI-1:0]        cli_ready_i;
    logic [N_CLI-1:0][W-1:0] cli_data_i;
    logic [N_CLI-1:0]        cli_valid_o;
    logic [N_CLI-1:0]        cli_ready_o;
    logic [N_CLI-1:0][W-1:0] cli_data_o;

    // Core control and streams
    logic                    core_start;
    logic [1:0]              core_mode;
    logic                    core_done;
    logic                    core_valid_i;
    logic                    core_ready_i;
    logic [W-1:0]            core_data_i;
    logic                    core_valid_o;
    logic                    core_ready_o;
    logic [W-1:0]            core_data_o;

    modport slave (
        input  req, mode0, mode1, cli_valid_i, cli_data_i, cli_ready_o,
               core_done, core_ready_i, core_valid_o, core_data_o,
        output gnt, cli_done, cli_ready_i, cli_valid_o, cli_data_o,
               core_start, core_mode, core_valid_i, core_data_i, core_ready_o
    );

    modport master (
        output req, mode0, mode1, cli_valid_i, cli_data_i, cli_ready_o,
               core_done, core_ready_i, core_valid_o, core_data_o,
        input  gnt, cli_done, cli_ready_i, cli_valid_o, cli_data_o,
               core_start, core_mode, core_valid_i, core_data_i, core_ready_o
    );
endinterface

// File: rtl/dilithium_core_arbiter.sv
// Two-client round-robin arbiter that time-shares one Dilithium core.
// Each job runs START -> RUN -> DONE. During the job, the owner's streams are muxed
// combinationally to and from the core.
// Optional build macro DILITHIUM_ARB_PERF_EN adds the last_cycles job-latency counter.
module dilithium_core_arbiter #(
    parameter int unsigned W     = 64,
    parameter int unsigned N_CLI = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    dilithium_core_arbiter_if.slave   bus
`ifdef DILITHIUM_ARB_PERF_EN
    ,
    output logic [31:0]               last_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic             owner, owner_next;
    logic             ptr, ptr_next;
    logic             win;
    logic [1:0]       mode_q, mode_next;
    logic [N_CLI-1:0] gnt_q, gnt_next;
    logic [N_CLI-1:0] done_q, done_next;
    logic             start_q, start_next;

    // Next-state, round-robin pick and next values of the registered outputs
    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        mode_next  = mode_q;
        gnt_next   = gnt_q;
        done_next  = '0;
        start_next = 1'b0;
        win        = ptr;
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    win           = bus.req[ptr] ? ptr : ~ptr;
                    state_next    = START;
                    owner_next    = win;
                    ptr_next      = ~win;
                    mode_next     = win ? bus.mode1 : bus.mode0;
                    start_next    = 1'b1;
                    gnt_next      = '0;
                    gnt_next[win] = 1'b1;
                end
            end
            START: state_next = RUN;
            RUN: begin
                if (bus.core_done) begin
                    state_next       = DONE;
                    done_next[owner] = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            mode_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            ptr     <= ptr_next;
            mode_q  <= mode_next;
            gnt_q   <= gnt_next;
            done_q  <= done_next;
            start_q <= start_next;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.cli_done   = done_q;
    assign bus.core_start = start_q;
    assign bus.core_mode  = mode_q;

    logic                    active_c;
    logic                    core_valid_i_c;
    logic                    core_ready_o_c;
    logic [W-1:0]            core_data_i_c;
    logic [N_CLI-1:0]        cli_ready_i_c;
    logic [N_CLI-1:0]        cli_valid_o_c;
    logic [N_CLI-1:0][W-1:0] cli_data_o_c;

    // Owner stream mux; everything held at zero while idle or in reset
    always_comb begin
        active_c       = (state != IDLE) && !rst;
        core_valid_i_c = 1'b0;
        core_ready_o_c = 1'b0;
        core_data_i_c  = '0;
        cli_ready_i_c  = '0;
        cli_valid_o_c  = '0;
        cli_data_o_c   = '0;
        if (active_c) begin
            core_valid_i_c       = bus.cli_valid_i[owner];
            core_data_i_c        = bus.cli_data_i[owner];
            core_ready_o_c       = bus.cli_ready_o[owner];
            cli_ready_i_c[owner] = bus.core_ready_i;
            cli_valid_o_c[owner] = bus.core_valid_o;
            cli_data_o_c[owner]  = bus.core_data_o;
        end
    end

    assign bus.core_valid_i = core_valid_i_c;
    assign bus.core_data_i  = core_data_i_c;
    assign bus.core_ready_o = core_ready_o_c;
    assign bus.cli_ready_i  = cli_ready_i_c;
    assign bus.cli_valid_o  = cli_valid_o_c;
    assign bus.cli_data_o   = cli_data_o_c;

`ifdef DILITHIUM_ARB_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] cyc_inc;

    assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

    // Job latency counter: the START cycle counts as 1; the core_done cycle is included
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt     <= '0;
            last_cycles <= '0;
        end else if (state == START) begin
            cyc_cnt <= 32'd1;
        end else if (state == RUN) begin
            cyc_cnt <= cyc_inc;
            if (bus.core_done) begin
                last_cycles <= cyc_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dilithium_core_arbiter.sv
// Self-checking bench for dilithium_core_arbiter. It uses a grant scoreboard plus a
// stream-mux vector table. Define DILITHIUM_ARB_PERF_EN to also exercise last_cycles.
module tb_dilithium_core_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dilithium_core_arbiter_if #(.W(64), .N_CLI(2)) bus ();

`ifdef DILITHIUM_ARB_PERF_EN
    logic [31:0] last_cycles;
`endif

    dilithium_core_arbiter #(.W(64), .N_CLI(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef DILITHIUM_ARB_PERF_EN
        ,
        .last_cycles (last_cycles)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected grants, popped on every core_start
    typedef struct packed {
        logic       own;
        logic [1:0] mode;
    } gexp_t;
    gexp_t exp_q[$];

    always @(negedge clk) begin
        if (bus.core_start) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL grant_unexpected: core_start with gnt=%b, none expected", bus.gnt);
            end else begin
                gexp_t g;
                g = exp_q.pop_front();
                chk("grant_gnt", 64'(bus.gnt), g.own ? 64'd2 : 64'd1);
                chk("grant_mode", 64'(bus.core_mode), 64'(g.mode));
            end
        end
    end

    // Stream-mux vectors, applied while the named owner is in RUN
    typedef struct {
        logic        own;
        logic [1:0]  vi;
        logic [1:0]  ro;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        cr;
        logic        cv;
        logic [63:0] cd;
        logic        e_cv;
        logic [63:0] e_cd;
        logic        e_cro;
        logic [1:0]  e_ri;
        logic [1:0]  e_vo;
        logic [63:0] e_do0;
        logic [63:0] e_do1;
    } vec_t;
    vec_t vecs[6];

    task automatic run_vecs(input logic cur_own);
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].own == cur_own) begin
                bus.cli_valid_i   = vecs[i].vi;
                bus.cli_ready_o   = vecs[i].ro;
                bus.cli_data_i[0] = vecs[i].d0;
                bus.cli_data_i[1] = vecs[i].d1;
                bus.core_ready_i  = vecs[i].cr;
                bus.core_valid_o  = vecs[i].cv;
                bus.core_data_o   = vecs[i].cd;
                #1;
                chk($sformatf("vec%0d_core_valid_i", i), 64'(bus.core_valid_i), 64'(vecs[i].e_cv));
                chk($sformatf("vec%0d_core_data_i", i), bus.core_data_i, vecs[i].e_cd);
                chk($sformatf("vec%0d_core_ready_o", i), 64'(bus.core_ready_o), 64'(vecs[i].e_cro));
                chk($sformatf("vec%0d_cli_ready_i", i), 64'(bus.cli_ready_i), 64'(vecs[i].e_ri));
                chk($sformatf("vec%0d_cli_valid_o", i), 64'(bus.cli_valid_o), 64'(vecs[i].e_vo));
                chk($sformatf("vec%0d_cli_data_o0", i), bus.cli_data_o[0], vecs[i].e_do0);
                chk($sformatf("vec%0d_cli_data_o1", i), bus.cli_data_o[1], vecs[i].e_do1);
                step();
            end
        end
    endtask

    task automatic clear_streams();
        bus.cli_valid_i  = '0;
        bus.cli_ready_o  = '0;
        bus.cli_data_i   = '0;
        bus.core_ready_i = 1'b0;
        bus.core_valid_o = 1'b0;
        bus.core_data_o  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //              own  vi     ro     d0          d1          cr    cv    cd          e_cv  e_cd        e_cro e_ri   e_vo   e_do0       e_do1
        vecs[0] = '{1'b0, 2'b11, 2'b00, 64'h1111, 64'hDEAD, 1'b1, 1'b0, 64'h0,    1'b1, 64'h1111, 1'b0, 2'b01, 2'b00, 64'h0,    64'h0};
        vecs[1] = '{1'b0, 2'b10, 2'b11, 64'h2222, 64'hDEAD, 1'b0, 1'b1, 64'hABCD, 1'b0, 64'h2222, 1'b1, 2'b00, 2'b01, 64'hABCD, 64'h0};
        vecs[2] = '{1'b0, 2'b01, 2'b10, 64'h3333, 64'h4444, 1'b1, 1'b1, 64'h5555, 1'b1, 64'h3333, 1'b0, 2'b01, 2'b01, 64'h5555, 64'h0};
        vecs[3] = '{1'b1, 2'b11, 2'b00, 64'h1111, 64'hBEEF, 1'b1, 1'b0, 64'h0,    1'b1, 64'hBEEF, 1'b0, 2'b10, 2'b00, 64'h0,    64'h0};
        vecs[4] = '{1'b1, 2'b01, 2'b10, 64'hAAAA, 64'h6666, 1'b0, 1'b1, 64'h7777, 1'b0, 64'h6666, 1'b1, 2'b00, 2'b10, 64'h0,    64'h7777};
        vecs[5] = '{1'b1, 2'b10, 2'b01, 64'hCCCC, 64'h8888, 1'b1, 1'b1, 64'h9999, 1'b1, 64'h8888, 1'b0, 2'b10, 2'b10, 64'h0,    64'h9999};

        bus.req = '0;
        bus.mode0 = '0;
        bus.mode1 = '0;
        bus.core_done = 1'b0;
        clear_streams();

        // Reset state, with stream inputs active
        rst = 1'b1;
        bus.cli_valid_i = 2'b11;
        bus.core_valid_o = 1'b1;
        step();
        step();
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_cli_done", 64'(bus.cli_done), 64'd0);
        chk("rst_core_start", 64'(bus.core_start), 64'd0);
        chk("rst_core_mode", 64'(bus.core_mode), 64'd0);
        chk("rst_cli_valid_o", 64'(bus.cli_valid_o), 64'd0);
        chk("rst_core_valid_i", 64'(bus.core_valid_i), 64'd0);
`ifdef DILITHIUM_ARB_PERF_EN
        chk("rst_last_cycles", 64'(last_cycles), 64'd0);
`endif
        rst = 1'b0;
        clear_streams();

        // Single request from client 0, mode 2'b10
        bus.req = 2'b01;
        bus.mode0 = 2'b10;
        bus.mode1 = 2'b01;
        exp_q.push_back('{own: 1'b0, mode: 2'b10});
        step();
        chk("a_core_start", 64'(bus.core_start), 64'd1);
        chk("a_core_mode", 64'(bus.core_mode), 64'd2);
        chk("a_gnt", 64'(bus.gnt), 64'd1);
        bus.req = 2'b00;
        step();
        chk("a_start_one_cycle", 64'(bus.core_start), 64'd0);
        chk("a_gnt_held_after_req_drop", 64'(bus.gnt), 64'd1);
        run_vecs(1'b0);
        clear_streams();
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        chk("a_cli_done", 64'(bus.cli_done), 64'd1);
        chk("a_gnt_in_done", 64'(bus.gnt), 64'd1);
        step();
        chk("a_cli_done_pulse", 64'(bus.cli_done), 64'd0);
        chk("a_gnt_dropped", 64'(bus.gnt), 64'd0);
        bus.cli_valid_i = 2'b11;
        bus.cli_ready_o = 2'b11;
        bus.core_valid_o = 1'b1;
        bus.core_ready_i = 1'b1;
        #1;
        chk("idle_core_valid_i", 64'(bus.core_valid_i), 64'd0);
        chk("idle_core_ready_o", 64'(bus.core_ready_o), 64'd0);
        chk("idle_cli_ready_i", 64'(bus.cli_ready_i), 64'd0);
        chk("idle_cli_valid_o", 64'(bus.cli_valid_o), 64'd0);
        clear_streams();

        // Client 1 job; a core_done during START is ignored
        bus.req = 2'b10;
        bus.mode1 = 2'b11;
        exp_q.push_back('{own: 1'b1, mode: 2'b11});
        step();
        chk("b_gnt", 64'(bus.gnt), 64'd2);
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        bus.req = 2'b00;
        step();
        chk("b_done_ignored_cli_done", 64'(bus.cli_done), 64'd0);
        chk("b_done_ignored_gnt", 64'(bus.gnt), 64'd2);
        run_vecs(1'b1);
        clear_streams();
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        chk("b_cli_done", 64'(bus.cli_done), 64'd2);
        step();
        chk("b_gnt_dropped", 64'(bus.gnt), 64'd0);

        // Both clients requesting through reset exit: order 0,1,0, back to back
        rst = 1'b1;
        bus.req = 2'b11;
        bus.mode0 = 2'b01;
        bus.mode1 = 2'b10;
        step();
        step();
        rst = 1'b0;
        exp_q.push_back('{own: 1'b0, mode: 2'b01});
        exp_q.push_back('{own: 1'b1, mode: 2'b10});
        exp_q.push_back('{own: 1'b0, mode: 2'b01});
        for (int j = 0; j < 3; j++) begin
            logic [1:0] eg;
            eg = (j == 1) ? 2'b10 : 2'b01;
            step();
            chk($sformatf("c%0d_core_start", j), 64'(bus.core_start), 64'd1);
            chk($sformatf("c%0d_gnt", j), 64'(bus.gnt), 64'(eg));
            step();
            bus.core_done = 1'b1;
            step();
            bus.core_done = 1'b0;
            chk($sformatf("c%0d_cli_done", j), 64'(bus.cli_done), 64'(eg));
            if (j == 2) bus.req = 2'b00;
            step();
            chk($sformatf("c%0d_idle_gap_gnt", j), 64'(bus.gnt), 64'd0);
            chk($sformatf("c%0d_idle_gap_start", j), 64'(bus.core_start), 64'd0);
        end

        // Pointer now favours client 1; client 0 alone still wins. Then reset mid-job
        bus.req = 2'b01;
        bus.mode0 = 2'b11;
        exp_q.push_back('{own: 1'b0, mode: 2'b11});
        step();
        chk("d_other_requester_gnt", 64'(bus.gnt), 64'd1);
        bus.req = 2'b00;
        step();
        bus.core_valid_o = 1'b1;
        bus.cli_ready_o = 2'b11;
        #1;
        chk("d_run_cli_valid_o", 64'(bus.cli_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("d_in_rst_cli_valid_o", 64'(bus.cli_valid_o), 64'd0);
        chk("d_in_rst_core_ready_o", 64'(bus.core_ready_o), 64'd0);
        step();
        chk("d_rst_gnt", 64'(bus.gnt), 64'd0);
        chk("d_rst_cli_valid_o", 64'(bus.cli_valid_o), 64'd0);
        chk("d_rst_core_mode", 64'(bus.core_mode), 64'd0);
        chk("d_rst_core_start", 64'(bus.core_start), 64'd0);
        rst = 1'b0;
        bus.req = 2'b11;
        bus.cli_valid_i = 2'b11;
        #1;
        chk("d_after_rst_cli_valid_o", 64'(bus.cli_valid_o), 64'd0);
        chk("d_after_rst_core_valid_i", 64'(bus.core_valid_i), 64'd0);
        exp_q.push_back('{own: 1'b0, mode: 2'b11});
        step();
        chk("d_ptr_reset_gnt", 64'(bus.gnt), 64'd1);
        bus.req = 2'b00;
        clear_streams();
        step();
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        step();
        chk("d_final_gnt", 64'(bus.gnt), 64'd0);

`ifdef DILITHIUM_ARB_PERF_EN
        // core_done 100 cycles after the core_start cycle
        bus.req = 2'b10;
        bus.mode1 = 2'b01;
        exp_q.push_back('{own: 1'b1, mode: 2'b01});
        step();
        bus.req = 2'b00;
        step();
        repeat (99) step();
        bus.core_done = 1'b1;
        step();
        bus.core_done = 1'b0;
        step();
        chk("perf_last_cycles", 64'(last_cycles), 64'd101);
`endif

        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dilithium_core_arbiter.md
DILITHIUM_CORE_ARBITER -- requirements
Module: dilithium_core_arbiter

Interface
REQ-001 Parameter W, default 64, data word width of both clients and core; SHALL equal the width of the wrapped Dilithium core.
REQ-002 Parameter N_CLI, fixed 2, number of clients; SHALL be 2 only.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  2  per-client level request; bit k held high by client k until it sees gnt[k].
REQ-006 mode0, mode1  input  2 each  operation mode of client 0/1; sampled at grant.
REQ-007 gnt  output  2  one-hot ownership; bit k high from START through DONE of client k's job.
REQ-008 cli_done  output  2  one-cycle pulse to the owning client at job end.
REQ-009 cli_valid_i, cli_ready_i, cli_data_i  in/out/in  2/2/2xW  per-client input stream.
REQ-010 cli_valid_o, cli_ready_o, cli_data_o  out/in/out  2/2/2xW  per-client output stream.
REQ-011 core_start, core_mode, core_done  out/out/in  1/2/1  core control; core_done is a one-cycle strobe.
REQ-012 core_valid_i, core_ready_i, core_data_i, core_valid_o, core_ready_o, core_data_o  out/in/out/in/out/in  1/1/W/1/1/W  core streams.

Function
REQ-013 FSM states IDLE, START, RUN, DONE; transitions IDLE->START (any req), START->RUN (always), RUN->DONE (core_done), DONE->IDLE (always).
REQ-014 In IDLE with req!=0, winner SHALL be chosen by round-robin: pointer p names the preferred client; if req[p] then p wins, else the other requester wins.
REQ-015 On the IDLE->START edge, owner index and core_mode (mode of winner) SHALL be registered; p SHALL become the non-winner.
REQ-016 core_start SHALL be high for exactly one cycle, in START; latency req-sampled to core_start = 1 cycle.
REQ-017 In START, RUN and DONE, owner's stream signals SHALL be combinationally muxed to/from the core; the non-owner SHALL see cli_ready_i=0, cli_valid_o=0, cli_data_o=0.
REQ-018 In IDLE, core_valid_i=0, core_ready_o=0, all cli_ready_i=0, all cli_valid_o=0.
REQ-019 core_done in any state other than RUN SHALL be ignored.
REQ-020 cli_done[owner] SHALL pulse in DONE, the cycle after core_done; gnt SHALL drop on DONE->IDLE.
REQ-021 A req deasserted mid-job SHALL NOT abort the job; the core runs to core_done.
REQ-022 Back-to-back: IDLE reached after DONE SHALL arbitrate in that same IDLE cycle; minimum idle gap between jobs is 1 cycle.
REQ-023 Simultaneous req=2'b11 with p=0: client 0 served first, then client 1, alternating while both hold req.

Reset
REQ-024 rst SHALL force state IDLE, p=0, owner=0, core_mode=0, gnt=0, cli_done=0, core_start=0, within one clock, including mid-job; core is reset by the same rst.
REQ-025 All muxed outputs SHALL be 0 during and the cycle after rst.

Configuration
REQ-026 Macro DILITHIUM_ARB_PERF_EN: when defined, output last_cycles (32-bit) SHALL hold the cycle count from core_start (counted as 1) to core_done inclusive of the last completed job, reset 0, saturating at 0xFFFFFFFF; when undefined, port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-027 req=2'b01, mode0=2'b10 -> core_start pulse 1 cycle later with core_mode=2'b10, gnt=2'b01.
REQ-028 req=2'b11 held at reset exit -> jobs granted in order 0,1,0 across three core_done strobes.
REQ-029 Owner 0 in RUN, client 1 drives cli_valid_i[1]=1 with data 0xDEAD -> cli_ready_i[1]=0, core_data_i equals client 0 data only.
REQ-030 core_done strobe in RUN -> cli_done[owner] high exactly next cycle, gnt=0 one cycle after.
REQ-031 rst asserted in RUN with core_valid_o=1 -> next cycle gnt=0, cli_valid_o=0, state IDLE, p=0.
REQ-032 PERF_EN build: core_done 100 cycles after core_start cycle -> last_cycles=101.
